// File: rtl/auto_record_writer.sv
// Record-mode front end for auto-play: times held keys and writes {note, duration} entries to song memory.
// Optional macro REST_RECORD_EN also records silent gaps between notes as rest entries (note 0).
module auto_record_writer #(
    parameter int DEPTH   = 25,
    parameter int MIN_DUR = 1000000,
    parameter int AW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          record_en,
    input  logic          key_on,
    input  logic [3:0]    key,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [3:0]    wr_note,
    output logic [25:0]   wr_duration,
    output logic [AW-1:0] song_len,
    output logic          full,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_KEY = 3'd1,
        S_HOLD     = 3'd2,
        S_COMMIT   = 3'd3,
        S_FULL     = 3'd4
    } state_t;

    localparam logic [25:0]   CNT_MAX   = 26'h3FFFFFF;
    localparam logic [25:0]   MIN_DUR_C = 26'(MIN_DUR);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    state_t        state_r;
    logic          record_en_q_r;
    logic [25:0]   counter_r;
    logic [3:0]    latched_r;
    logic [AW-1:0] addr_r;
`ifdef REST_RECORD_EN
    logic [25:0]   idle_r;
    logic          has_note_r;
`endif

    // Saturating 26-bit increment shared by the hold and idle timers.
    function automatic logic [25:0] sat_inc(input logic [25:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + 26'd1;
        end
    endfunction

    // Recording FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            record_en_q_r <= 1'b0;
            counter_r     <= 26'd0;
            latched_r     <= 4'd0;
            addr_r        <= {AW{1'b0}};
            wr_en         <= 1'b0;
            wr_addr       <= {AW{1'b0}};
            wr_note       <= 4'd0;
            wr_duration   <= 26'd0;
            song_len      <= {AW{1'b0}};
            full          <= 1'b0;
            busy          <= 1'b0;
`ifdef REST_RECORD_EN
            idle_r        <= 26'd0;
            has_note_r    <= 1'b0;
`endif
        end else begin
            record_en_q_r <= record_en;
            wr_en         <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (record_en && !record_en_q_r) begin
                        addr_r   <= {AW{1'b0}};
                        wr_addr  <= {AW{1'b0}};
                        song_len <= {AW{1'b0}};
                        full     <= 1'b0;
                        state_r  <= S_WAIT_KEY;
`ifdef REST_RECORD_EN
                        idle_r     <= 26'd0;
                        has_note_r <= 1'b0;
`endif
                    end
                end
                S_WAIT_KEY: begin
                    if (!record_en) begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (key_on && (key != 4'd0)) begin
                        latched_r <= key;
                        counter_r <= 26'd1;
`ifdef REST_RECORD_EN
                        if (has_note_r && (idle_r >= MIN_DUR_C)) begin
                            wr_en       <= 1'b1;
                            wr_note     <= 4'd0;
                            wr_duration <= idle_r;
                            wr_addr     <= addr_r;
                            song_len    <= addr_r + ADDR_ONE;
                            if (addr_r == LAST_ADDR) begin
                                // The rest took the last slot; the pressed note has nowhere to go.
                                full    <= 1'b1;
                                state_r <= S_FULL;
                            end else begin
                                addr_r  <= addr_r + ADDR_ONE;
                                busy    <= 1'b1;
                                state_r <= S_HOLD;
                            end
                        end else begin
                            busy    <= 1'b1;
                            state_r <= S_HOLD;
                        end
`else
                        busy    <= 1'b1;
                        state_r <= S_HOLD;
`endif
                    end else begin
`ifdef REST_RECORD_EN
                        idle_r <= sat_inc(idle_r);
`endif
                    end
                end
                S_HOLD: begin
                    if (!record_en) begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (key_on && (key == latched_r)) begin
                        counter_r <= sat_inc(counter_r);
                    end else if (counter_r >= MIN_DUR_C) begin
                        state_r <= S_COMMIT;
`ifdef REST_RECORD_EN
                        idle_r <= 26'd1;
`endif
                    end else begin
                        // Too short: treated as key bounce and dropped.
                        busy    <= 1'b0;
                        state_r <= S_WAIT_KEY;
`ifdef REST_RECORD_EN
                        idle_r <= 26'd1;
`endif
                    end
                end
                S_COMMIT: begin
                    wr_en       <= 1'b1;
                    wr_note     <= latched_r;
                    wr_duration <= counter_r;
                    wr_addr     <= addr_r;
                    song_len    <= addr_r + ADDR_ONE;
                    busy        <= 1'b0;
`ifdef REST_RECORD_EN
                    has_note_r  <= 1'b1;
                    idle_r      <= 26'd2;
`endif
                    if (addr_r == LAST_ADDR) begin
                        full    <= 1'b1;
                        state_r <= record_en ? S_FULL : S_IDLE;
                    end else begin
                        addr_r  <= addr_r + ADDR_ONE;
                        state_r <= record_en ? S_WAIT_KEY : S_IDLE;
                    end
                end
                S_FULL: begin
                    busy <= 1'b0;
                    full <= 1'b1;
                    if (!record_en) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auto_record_writer.sv
// Randomized self-checking bench for auto_record_writer against a note-level song model.
module tb_auto_record_writer;

    localparam int DEPTH   = 4;
    localparam int MIN_DUR = 4;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          record_en;
    logic          key_on;
    logic [3:0]    key;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_note;
    logic [25:0]   wr_duration;
    logic [AW-1:0] song_len;
    logic          full;
    logic          busy;

    auto_record_writer #(.DEPTH(DEPTH), .MIN_DUR(MIN_DUR), .AW(AW)) dut (
        .clk(clk), .rst(rst), .record_en(record_en), .key_on(key_on), .key(key),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_duration(wr_duration),
        .song_len(song_len), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    note;
        logic [25:0]   dur;
        logic [AW-1:0] addr;
    } entry_t;

    entry_t exp_q[$];
    entry_t obs_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    logic   prev_wr = 1'b0;

    // Model of the recorded song: entries, fill level, and silence before the next press.
    int m_addr = 0;
    bit m_full = 1'b0;
    bit m_rec  = 1'b0;
    bit m_has_note = 1'b0;
    int m_gap  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every write strobe; two strobes in a row are never legal.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            obs_q.push_back('{wr_note, wr_duration, wr_addr});
            check("wr_en_back_to_back", 64'(prev_wr), 64'd0);
        end
        prev_wr <= wr_en;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_entry(input logic [3:0] note, input int dur);
        exp_q.push_back('{note, 26'(dur), AW'(m_addr)});
        m_addr++;
        if (m_addr == DEPTH) m_full = 1'b1;
    endtask

    task automatic model_note(input logic [3:0] k, input int dur);
        if (m_rec && !m_full && dur >= MIN_DUR) begin
            model_entry(k, dur);
            m_has_note = 1'b1;
        end
    endtask

    // A press leaving the waiting state may first emit a rest entry.
    task automatic model_pickup(output bit dropped);
        dropped = 1'b0;
`ifdef REST_RECORD_EN
        if (m_rec && !m_full && m_has_note && m_gap >= MIN_DUR) begin
            model_entry(4'd0, m_gap);
            dropped = m_full;
        end
`endif
    endtask

    task automatic press(input logic [3:0] k, input int len, input int gap);
        bit dropped;
        model_pickup(dropped);
        key_on = 1'b1; key = k;
        step(len);
        key_on = 1'b0; key = 4'd0;
        step(gap);
        if (!dropped) model_note(k, len);
        m_gap = gap;
    endtask

    // Key k1 changes straight to k2; the second note loses the cycles spent closing the first.
    task automatic press_change(input logic [3:0] k1, input int l1, input logic [3:0] k2,
                                input int l2, input int gap);
        bit dropped;
        model_pickup(dropped);
        key_on = 1'b1; key = k1;
        step(l1);
        key = k2;
        step(l2);
        key_on = 1'b0; key = 4'd0;
        step(gap);
        if (!dropped) begin
            model_note(k1, l1);
            m_gap = (l1 >= MIN_DUR) ? 2 : 1;
            model_pickup(dropped);
            if (!dropped) model_note(k2, l2 - m_gap);
        end
        m_gap = gap;
    endtask

    task automatic restart_record();
        record_en = 1'b0;
        step(2);
        m_rec = 1'b0;
        record_en = 1'b1;
        step(2);
        m_rec = 1'b1; m_addr = 0; m_full = 1'b0; m_has_note = 1'b0;
    endtask

    task automatic compare(input string tag);
        int n;
        @(negedge clk);
        #1;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_note"}, 64'(obs_q[i].note), 64'(exp_q[i].note));
            check({tag, "_dur"},  64'(obs_q[i].dur),  64'(exp_q[i].dur));
            check({tag, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_song_len"}, 64'(song_len), 64'(m_addr));
        check({tag, "_full"}, 64'(full), 64'(m_full));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; record_en = 1'b0; key_on = 1'b0; key = 4'd0;
        step(2);
        check("reset_outputs", {54'd0, wr_en, wr_addr, song_len, full, busy},
              {54'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0});
        rst = 1'b0;
        step(1);

        // Asynchronous reset while a note is being timed.
        record_en = 1'b1;
        step(2);
        key_on = 1'b1; key = 4'd5;
        step(7);
        check("hold_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_outs", {wr_en, wr_addr, wr_note, wr_duration, song_len, full},
              {1'b0, 3'd0, 4'd0, 26'd0, 3'd0, 1'b0});
        record_en = 1'b0; key_on = 1'b0; key = 4'd0;
        step(2);
        rst = 1'b0;
        step(3);
        compare("after_reset");

        // Directed song: valid note, bounce, key change, fill, overflow press.
        restart_record();
        press(4'd5, 10, 3);
        compare("note5");
        press(4'd3, 2, 3);
        compare("bounce");
        press_change(4'd2, 6, 4'd7, 7, 3);
        compare("key_change");
        press(4'd9, 5, 3);
        compare("fill");
        press(4'd6, 8, 3);
        compare("overflow");
        restart_record();
        compare("restart");

        // Random presses with periodic record restarts.
        for (int i = 0; i < 40; i++) begin
            if ((i % 9 == 8) || (m_full && ($urandom_range(0, 1) == 1))) restart_record();
            if ($urandom_range(0, 4) == 0) begin
                press_change(4'($urandom_range(1, 15)), $urandom_range(4, 8),
                             4'($urandom_range(1, 15)), $urandom_range(3, 8),
                             $urandom_range(2, 3));
            end else begin
                press(4'($urandom_range(1, 15)), $urandom_range(1, 9), $urandom_range(2, 3));
            end
            compare("random");
        end

`ifdef REST_RECORD_EN
        restart_record();
        press(4'd1, 5, 8);
        press(4'd4, 6, 3);
        compare("rest");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
